// File: rtl/mcu_pixel_loader.sv
// MCU pixel loader: buffers pixel bytes from an MCU in a small FIFO and writes them
// to SRAM port A, one pixel per cycle, while the dithering controller is in its store phase.
module mcu_pixel_loader #(
    parameter int IMAGEX           = 64,
    parameter int IMAGEY           = 64,
    parameter int RGB_SIZE         = 8,
    parameter int FIFO_DEPTH       = 4,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RGB_SIZE-1:0]         mcu_data,
    input  logic                        mcu_valid,
    output logic                        mcu_ready,
    input  logic                        store_sram,
    output logic                        MCU_TX_RDY,
    output logic                        wr_en,
    output logic [IMAGE_ADDR_WIDTH-1:0] wr_addr,
    output logic [RGB_SIZE-1:0]         wr_data,
    output logic                        load_done,
    output logic                        seq_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int AW = IMAGE_ADDR_WIDTH;
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   SIZE_C    = (AW+1)'(IMAGE_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   ACC_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [RGB_SIZE-1:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         wp_q, rp_q;
    logic [PW:0]           cnt_q, cnt_d;
    logic [AW:0]           acc_q, acc_d;
    logic [AW-1:0]         wr_ptr_q;
    logic                  ready_q, ready_d;
    logic                  tx_rdy_q, wr_en_q, load_done_q, seq_err_q, store_prev_q;
    logic [AW-1:0]         wr_addr_q;
    logic [RGB_SIZE-1:0]   wr_data_q;
    logic                  push, pop, frame_clr, err_d;

    // Handshake: a byte moves on every rising edge where mcu_valid and mcu_ready are both 1;
    // mcu_ready is a register, so it never depends on mcu_valid or store_sram in the same cycle.
    always_comb begin
        push      = mcu_valid && ready_q;
        pop       = (state_q == WRITE) && store_sram && (cnt_q != '0);
        frame_clr = (state_q == DONE) && !store_sram;
        err_d     = ((state_q == WRITE) && store_prev_q && !store_sram) ||
                    ((state_q == IDLE) && store_sram);

        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = FILL;
            FILL:    if (store_sram) state_d = WRITE;
            WRITE:   if (pop && (wr_ptr_q == LAST_ADDR)) state_d = DONE;
            DONE:    if (!store_sram) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if (frame_clr) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        acc_d = acc_q;
        if (frame_clr) begin
            acc_d = '0;
        end else if (push && (acc_q != SIZE_C)) begin
            acc_d = acc_q + ACC_ONE;
        end

        ready_d = (cnt_d < DEPTH_C) && (acc_d < SIZE_C) && (state_d != DONE);
    end

    // Storage has no reset: reads are gated by the count, which does reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= mcu_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            wp_q         <= '0;
            rp_q         <= '0;
            wr_ptr_q     <= '0;
            ready_q      <= 1'b0;
            tx_rdy_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            store_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            ready_q      <= ready_d;
            tx_rdy_q     <= (state_d == FILL) || (state_d == WRITE);
            seq_err_q    <= seq_err_q || err_d;
            store_prev_q <= store_sram;
            wr_en_q      <= pop;
            load_done_q  <= pop && (wr_ptr_q == LAST_ADDR);
            if (pop) begin
                wr_addr_q <= wr_ptr_q;
                wr_data_q <= fifo_q[rp_q];
            end
            if (frame_clr) begin
                wp_q     <= '0;
                rp_q     <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wp_q <= wp_q + PTR_ONE;
                if (pop) begin
                    rp_q <= rp_q + PTR_ONE;
                    if (wr_ptr_q != LAST_ADDR) wr_ptr_q <= wr_ptr_q + ADDR_ONE;
                end
            end
        end
    end

    assign mcu_ready  = ready_q;
    assign MCU_TX_RDY = tx_rdy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign load_done  = load_done_q;
    assign seq_err    = seq_err_q;
endmodule

// File: tb/tb_mcu_pixel_loader.sv
// Bench for mcu_pixel_loader on a 4x4 image: scoreboard of expected {addr, data} writes,
// filled as bytes are accepted and drained as the loader writes SRAM.
module tb_mcu_pixel_loader;
    localparam int IX = 4;
    localparam int IY = 4;
    localparam int RGB = 8;
    localparam int DEPTH = 4;
    localparam int SIZE = IX * IY;
    localparam int AW = 4;
    localparam int W = AW + RGB;
    localparam int BUDGET = 400;

    logic           clk = 1'b0;
    logic           rst;
    logic [RGB-1:0] mcu_data;
    logic           mcu_valid;
    logic           mcu_ready;
    logic           store_sram;
    logic           MCU_TX_RDY;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [RGB-1:0] wr_data;
    logic           load_done;
    logic           seq_err;

    always #5 clk = ~clk;

    mcu_pixel_loader #(
        .IMAGEX(IX), .IMAGEY(IY), .RGB_SIZE(RGB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .mcu_data(mcu_data), .mcu_valid(mcu_valid),
        .mcu_ready(mcu_ready), .store_sram(store_sram), .MCU_TX_RDY(MCU_TX_RDY),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_done(load_done), .seq_err(seq_err)
    );

    int             n_checks = 0;
    int             n_pass = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_e;
    int             acc_idx = 0;
    int             n_wr = 0;
    int             bubbles = 0;
    bit             hold_chk = 0;
    bit             have_last = 0;
    bit             abort = 0;
    logic [AW-1:0]  last_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: every SRAM write must match the oldest accepted byte.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {28'd0, wr_addr}, {28'd0, mon_e[W-1:RGB]});
                check("wr_data", {24'd0, wr_data}, {24'd0, mon_e[RGB-1:0]});
                check("load_done", {31'd0, load_done}, {31'd0, (mon_e[W-1:RGB] == AW'(SIZE - 1))});
            end
            last_addr = wr_addr;
            have_last = 1;
        end else if (hold_chk && have_last) begin
            bubbles++;
            check("addr_hold", {28'd0, wr_addr}, {28'd0, last_addr});
        end
    end

    task automatic send(input logic [RGB-1:0] d);
        int t = 0;
        mcu_data = d;
        mcu_valid = 1'b1;
        while (mcu_ready !== 1'b1 && !abort && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (t >= BUDGET) check("send_timeout", {31'd0, mcu_ready}, 1);
        if (mcu_ready === 1'b1 && !abort) begin
            exp_q.push_back({AW'(acc_idx), d});
            acc_idx++;
        end
        @(negedge clk);
        mcu_valid = 1'b0;
    endtask

    task automatic stream(input logic [RGB-1:0] base, input int gap);
        for (int i = 0; i < SIZE; i++) begin
            if (abort) break;
            send(base + RGB'(i));
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_first_accept();
        int t = 0;
        while (acc_idx == 0 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (t >= BUDGET) check("accept_timeout", acc_idx, 1);
    endtask

    task automatic wait_ld();
        int t = 0;
        while (load_done !== 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check("frame_done", {31'd0, load_done}, 1);
        check("tx_rdy_done", {31'd0, MCU_TX_RDY}, 0);
    endtask

    task automatic wait_wr(input logic [AW-1:0] a);
        int t = 0;
        while (!(wr_en === 1'b1 && wr_addr == a) && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check("wait_addr", {28'd0, wr_addr}, {28'd0, a});
    endtask

    task automatic store_ctrl(input int delay);
        wait_first_accept();
        repeat (delay) @(negedge clk);
        store_sram = 1'b1;
        @(negedge clk);
        check("tx_rdy_busy", {31'd0, MCU_TX_RDY}, 1);
        wait_ld();
        store_sram = 1'b0;
    endtask

    task automatic end_frame();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("write_count", n_wr, SIZE);
        check("tx_rdy_idle", {31'd0, MCU_TX_RDY}, 0);
        check("ready_idle", {31'd0, mcu_ready}, 1);
        n_wr = 0;
        acc_idx = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        rst = 1'b1;
        mcu_valid = 1'b0;
        mcu_data = '0;
        store_sram = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, mcu_ready}, 0);
        check("rst_tx", {31'd0, MCU_TX_RDY}, 0);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_addr", {28'd0, wr_addr}, 0);
        check("rst_data", {24'd0, wr_data}, 0);
        check("rst_ld", {31'd0, load_done}, 0);
        check("rst_err", {31'd0, seq_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, mcu_ready}, 1);
        check("rel_tx", {31'd0, MCU_TX_RDY}, 0);
        check("rel_wr_en", {31'd0, wr_en}, 0);
        check("rel_err", {31'd0, seq_err}, 0);

        // Full frame, back-to-back bytes.
        fork
            stream(8'h10, 0);
            store_ctrl(2);
        join
        end_frame();
        check("err_clean", {31'd0, seq_err}, 0);

        // Store phase withheld: FIFO fills, then drains at full rate.
        fork
            stream(8'h40, 0);
            begin
                repeat (12) @(negedge clk);
                check("stall_accepted", acc_idx, DEPTH);
                check("stall_ready", {31'd0, mcu_ready}, 0);
                check("stall_writes", n_wr, 0);
                store_sram = 1'b1;
                t = 0;
                while (wr_en !== 1'b1 && t < BUDGET) begin
                    @(negedge clk);
                    t++;
                end
                n = 0;
                while (load_done !== 1'b1 && t < BUDGET) begin
                    @(negedge clk);
                    n++;
                    t++;
                end
                check("drain_cycles", n, SIZE - 1);
                store_sram = 1'b0;
            end
        join
        end_frame();

        // Bursty MCU: a byte every third cycle.
        hold_chk = 1;
        have_last = 0;
        bubbles = 0;
        fork
            stream(8'h20, 2);
            store_ctrl(2);
        join
        hold_chk = 0;
        check("bursty_bubbles", {31'd0, (bubbles > 0)}, 1);
        end_frame();

        // store_sram dropped mid-write.
        fork
            stream(8'h60, 0);
            begin
                wait_first_accept();
                repeat (2) @(negedge clk);
                store_sram = 1'b1;
                wait_wr(AW'(5));
                store_sram = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("pause_wr_en", {31'd0, wr_en}, 0);
                    check("pause_seq_err", {31'd0, seq_err}, 1);
                end
                store_sram = 1'b1;
                @(negedge clk);
                check("resume_wr_en", {31'd0, wr_en}, 1);
                check("resume_addr", {28'd0, wr_addr}, 6);
                wait_ld();
                store_sram = 1'b0;
            end
        join
        end_frame();
        check("seq_err_sticky", {31'd0, seq_err}, 1);

        // Reset mid-frame, then a fresh frame.
        fork
            stream(8'h70, 0);
            begin
                wait_first_accept();
                repeat (2) @(negedge clk);
                store_sram = 1'b1;
                wait_wr(AW'(9));
                abort = 1;
                rst = 1'b1;
                store_sram = 1'b0;
                @(negedge clk);
                check("mid_rst_addr", {28'd0, wr_addr}, 0);
                check("mid_rst_wr_en", {31'd0, wr_en}, 0);
                check("mid_rst_tx", {31'd0, MCU_TX_RDY}, 0);
                check("mid_rst_ready", {31'd0, mcu_ready}, 0);
                check("mid_rst_err", {31'd0, seq_err}, 0);
            end
        join
        @(negedge clk);
        exp_q.delete();
        acc_idx = 0;
        n_wr = 0;
        mcu_valid = 1'b0;
        abort = 0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, mcu_ready}, 1);
        fork
            stream(8'h80, 0);
            store_ctrl(2);
        join
        end_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
